// File: rtl/lsu_pkg.sv
// Shared definitions for the RV64I load/store unit: funct3 codes, FSM states
// and the access-size decode.
package lsu_pkg;

    localparam int LANES = 8;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_BAD = 3'b111;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } lsu_state_t;

    // Access size minus one (1/2/4/8 bytes -> 0/1/3/7): the low-address mask
    // that must be clear for a naturally aligned access.
    function automatic logic [2:0] size_decode(input logic [2:0] funct3);
        return (3'b001 << funct3[1:0]) - 3'b001;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: store shift/strobes and
// load extract with sign or zero extension. Purely combinational.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      funct3,
    input  logic [2:0]      offset,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] st_wdata,
    output logic [LANES-1:0] st_wstrb,
    output logic [XLEN-1:0] ld_data
);

    logic [XLEN-1:0]  shifted_s;
    logic [LANES-1:0] base_strb_s;

    // Store data shifted into its lanes and the matching byte strobes.
    always_comb begin
        st_wdata = wdata << {offset, 3'b000};
        case (funct3[1:0])
            2'b00:   base_strb_s = 8'h01;
            2'b01:   base_strb_s = 8'h03;
            2'b10:   base_strb_s = 8'h0F;
            2'b11:   base_strb_s = 8'hFF;
            default: base_strb_s = 8'h00;
        endcase
        st_wstrb = base_strb_s << offset;
    end

    // Load data brought down to lane 0 and extended per funct3.
    always_comb begin
        shifted_s = rdata >> {offset, 3'b000};
        case (funct3)
            F3_LB:   ld_data = {{(XLEN-8){shifted_s[7]}},   shifted_s[7:0]};
            F3_LH:   ld_data = {{(XLEN-16){shifted_s[15]}}, shifted_s[15:0]};
            F3_LW:   ld_data = {{(XLEN-32){shifted_s[31]}}, shifted_s[31:0]};
            F3_LD:   ld_data = shifted_s;
            F3_LBU:  ld_data = {{(XLEN-8){1'b0}},  shifted_s[7:0]};
            F3_LHU:  ld_data = {{(XLEN-16){1'b0}}, shifted_s[15:0]};
            F3_LWU:  ld_data = {{(XLEN-32){1'b0}}, shifted_s[31:0]};
            default: ld_data = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV64I load/store unit: one req/ack data-memory transaction per accepted op.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of aligning them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int XLEN   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [2:0]        funct3,
    input  logic              is_store,
    input  logic [4:0]        rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [LANES-1:0]  mem_wstrb,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_rdata,
    output logic [4:0]        out_rd,
    output logic              out_fault
);

    lsu_state_t       state_r;
    logic [2:0]       funct3_r;
    logic [2:0]       offset_r;
    logic [4:0]       rd_r;
    logic             is_store_r;

    logic [2:0]       mask_s;
    logic             legal_s;
    logic             fault_s;
    logic [2:0]       offset_s;
    logic [2:0]       align_f3_s;
    logic [2:0]       align_off_s;
    logic [XLEN-1:0]  st_wdata_s;
    logic [LANES-1:0] st_wstrb_s;
    logic [XLEN-1:0]  ld_data_s;

    // Legality, alignment and effective lane offset of the op being presented.
    always_comb begin
        mask_s = size_decode(funct3);
        if (is_store) begin
            legal_s = ~funct3[2];
        end else begin
            legal_s = (funct3 != F3_BAD);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        fault_s  = ~legal_s | ((addr[2:0] & mask_s) != 3'b000);
        offset_s = addr[2:0];
`else
        fault_s  = ~legal_s;
        offset_s = addr[2:0] & ~mask_s;
`endif
    end

    // The aligner sees the incoming op at accept time and the latched op afterwards.
    always_comb begin
        if (state_r == ST_IDLE) begin
            align_f3_s  = funct3;
            align_off_s = offset_s;
        end else begin
            align_f3_s  = funct3_r;
            align_off_s = offset_r;
        end
    end

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3   (align_f3_s),
        .offset   (align_off_s),
        .wdata    (wdata),
        .rdata    (mem_rdata),
        .st_wdata (st_wdata_s),
        .st_wstrb (st_wstrb_s),
        .ld_data  (ld_data_s)
    );

    // Transaction FSM with all interface outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            funct3_r   <= 3'b000;
            offset_r   <= 3'b000;
            rd_r       <= 5'd0;
            is_store_r <= 1'b0;
            in_ready   <= 1'b1;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= {ADDR_W{1'b0}};
            mem_wdata  <= {XLEN{1'b0}};
            mem_wstrb  <= {LANES{1'b0}};
            out_valid  <= 1'b0;
            out_rdata  <= {XLEN{1'b0}};
            out_rd     <= 5'd0;
            out_fault  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        funct3_r   <= funct3;
                        offset_r   <= offset_s;
                        rd_r       <= rd;
                        is_store_r <= is_store;
                        in_ready   <= 1'b0;
                        if (fault_s) begin
                            // Faulting ops skip memory entirely.
                            state_r   <= ST_RESP;
                            out_valid <= 1'b1;
                            out_fault <= 1'b1;
                            out_rdata <= {XLEN{1'b0}};
                            out_rd    <= is_store ? 5'd0 : rd;
                        end else begin
                            state_r   <= ST_REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[ADDR_W-1:3], 3'b000};
                            mem_wdata <= is_store ? st_wdata_s : {XLEN{1'b0}};
                            mem_wstrb <= is_store ? st_wstrb_s : {LANES{1'b0}};
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        state_r   <= ST_RESP;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= {LANES{1'b0}};
                        out_valid <= 1'b1;
                        out_fault <= 1'b0;
                        out_rdata <= is_store_r ? {XLEN{1'b0}} : ld_data_s;
                        out_rd    <= is_store_r ? 5'd0 : rd_r;
                    end
                end
                ST_RESP: begin
                    if (out_ready) begin
                        state_r   <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    in_ready  <= 1'b1;
                    mem_req   <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, randomized
// ops against a byte-level reference model, and reset/backpressure sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  funct3;
    logic        is_store;
    logic [4:0]  rd;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_rdata;
    logic [4:0]  out_rd;
    logic        out_fault;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .addr(addr), .wdata(wdata), .funct3(funct3), .is_store(is_store), .rd(rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_rd(out_rd), .out_fault(out_fault)
    );

    typedef struct packed {
        logic        st;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic [4:0]  rd;
    } op_t;

    typedef struct packed {
        logic        fault;
        logic [63:0] maddr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [63:0] rdata;
        logic [4:0]  rd;
    } exp_t;

    typedef struct packed {
        op_t  op;
        exp_t e;
    } vec_t;

    typedef struct packed {
        logic        ready_at_start;
        logic        saw_req;
        logic [63:0] maddr;
        logic        mwe;
        logic [63:0] mwdata;
        logic [7:0]  mwstrb;
        logic        saw_valid;
        logic [7:0]  lat;
        logic [63:0] rdata;
        logic [4:0]  rd;
        logic        fault;
        logic        unstable;
        logic        inready_bad;
        logic        timeout;
        logic        idle_after;
    } res_t;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference: what the access should do, from size/offset arithmetic.
    function automatic exp_t model(input op_t op);
        exp_t        e;
        int          size;
        int          off;
        bit          ill;
        logic [63:0] v;
        logic [63:0] lowmask;
        logic [15:0] strb;
        e       = '0;
        size    = 1 << op.f3[1:0];
        off     = int'(op.addr % 64'd8);
        ill     = op.st ? op.f3[2] : (op.f3 == 3'd7);
`ifdef LSU_MISALIGN_TRAP_EN
        e.fault = ill || ((off % size) != 0);
`else
        e.fault = ill;
        off     = off - (off % size);
`endif
        e.maddr = op.addr - (op.addr % 64'd8);
        if (e.fault) begin
            e.rd = op.st ? 5'd0 : op.rd;
        end else if (op.st) begin
            e.wdata = op.wdata << (8 * off);
            strb    = ((16'd1 << size) - 16'd1) << off;
            e.wstrb = strb[7:0];
        end else begin
            v = op.rdata >> (8 * off);
            if (size < 8) begin
                lowmask = (64'd1 << (8 * size)) - 64'd1;
                v = v & lowmask;
                if (!op.f3[2] && v[8*size-1]) v = v | ~lowmask;
            end
            e.rdata = v;
            e.rd    = op.rd;
        end
        return e;
    endfunction

    // Drive one op and observe the handshake until the result is consumed.
    task automatic run_op(input op_t op, input int ack_dly, input int rdy_dly, output res_t r);
        int req_n;
        int val_n;
        bit done;
        r = '0;
        @(negedge clk);
        r.ready_at_start = in_ready;
        in_valid = 1'b1; is_store = op.st; funct3 = op.f3; addr = op.addr;
        wdata = op.wdata; rd = op.rd;
        @(negedge clk);
        in_valid = 1'b0; addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
        req_n = 0; val_n = 0; done = 1'b0;
        for (int c = 1; c <= 60 && !done; c++) begin
            mem_ack = 1'b0; out_ready = 1'b0; mem_rdata = {$urandom, $urandom};
            if (in_ready) r.inready_bad = 1'b1;
            if (mem_req) begin
                if (!r.saw_req) begin
                    r.saw_req = 1'b1; r.maddr = mem_addr; r.mwe = mem_we;
                    r.mwdata = mem_wdata; r.mwstrb = mem_wstrb;
                end else if (r.maddr !== mem_addr || r.mwe !== mem_we ||
                             r.mwdata !== mem_wdata || r.mwstrb !== mem_wstrb) begin
                    r.unstable = 1'b1;
                end
                if (req_n >= ack_dly) begin
                    mem_ack = 1'b1; mem_rdata = op.rdata;
                end
                req_n++;
            end
            if (out_valid) begin
                if (!r.saw_valid) begin
                    r.saw_valid = 1'b1; r.lat = 8'(c); r.rdata = out_rdata;
                    r.rd = out_rd; r.fault = out_fault;
                end else if (r.rdata !== out_rdata || r.rd !== out_rd || r.fault !== out_fault) begin
                    r.unstable = 1'b1;
                end
                if (val_n >= rdy_dly) begin
                    out_ready = 1'b1; done = 1'b1;
                end
                val_n++;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0; out_ready = 1'b0;
        r.timeout    = !done;
        r.idle_after = in_ready && !out_valid && !mem_req;
        @(negedge clk);
        if (out_valid || mem_req) r.idle_after = 1'b0;
    endtask

    task automatic check_res(input string tag, input op_t op, input exp_t e, input res_t r, input int lat);
        chk({tag, "_ready_start"}, r.ready_at_start, 1'b1);
        chk({tag, "_timeout"}, r.timeout, 1'b0);
        chk({tag, "_req_issued"}, r.saw_req, !e.fault);
        chk({tag, "_fault"}, r.fault, e.fault);
        chk({tag, "_latency"}, r.lat, e.fault ? 1 : lat);
        chk({tag, "_rdata"}, r.rdata, e.rdata);
        chk({tag, "_rd"}, r.rd, e.rd);
        chk({tag, "_stable"}, r.unstable, 1'b0);
        chk({tag, "_busy_inready"}, r.inready_bad, 1'b0);
        chk({tag, "_single_result"}, r.idle_after, 1'b1);
        if (!e.fault) begin
            chk({tag, "_maddr"}, r.maddr, e.maddr);
            chk({tag, "_we"}, r.mwe, op.st);
            chk({tag, "_wstrb"}, r.mwstrb, e.wstrb);
            if (op.st) chk({tag, "_wdata"}, r.mwdata, e.wdata);
        end
    endtask

    vec_t vecs[10];
    res_t res;
    op_t  op;
    exp_t ex;
    int   ad;
    int   rdl;

    initial begin
        // st, f3, addr, wdata, rdata, rd  |  fault, maddr, wdata, wstrb, rdata, rd
        vecs[0] = '{'{1'b0, 3'b010, 64'h1004, 64'h0, 64'h8000_0001_1234_5678, 5'd7},
                    '{1'b0, 64'h1000, 64'h0, 8'h00, 64'hFFFF_FFFF_8000_0001, 5'd7}};
        vecs[1] = '{'{1'b0, 3'b100, 64'h2007, 64'h0, 64'hF000_0000_0000_0000, 5'd1},
                    '{1'b0, 64'h2000, 64'h0, 8'h00, 64'h0000_0000_0000_00F0, 5'd1}};
        vecs[2] = '{'{1'b0, 3'b000, 64'h2007, 64'h0, 64'hF000_0000_0000_0000, 5'd2},
                    '{1'b0, 64'h2000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFF0, 5'd2}};
        vecs[3] = '{'{1'b1, 3'b001, 64'h3002, 64'hABCD, 64'h0, 5'd5},
                    '{1'b0, 64'h3000, 64'h0000_0000_ABCD_0000, 8'b0000_1100, 64'h0, 5'd0}};
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[4] = '{'{1'b1, 3'b011, 64'h4004, 64'h1122_3344_5566_7788, 64'h0, 5'd6},
                    '{1'b1, 64'h0, 64'h0, 8'h00, 64'h0, 5'd0}};
        vecs[5] = '{'{1'b0, 3'b110, 64'h6006, 64'h0, 64'hDEAD_BEEF_0000_0000, 5'd11},
                    '{1'b1, 64'h0, 64'h0, 8'h00, 64'h0, 5'd11}};
`else
        vecs[4] = '{'{1'b1, 3'b011, 64'h4004, 64'h1122_3344_5566_7788, 64'h0, 5'd6},
                    '{1'b0, 64'h4000, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, 5'd0}};
        vecs[5] = '{'{1'b0, 3'b110, 64'h6006, 64'h0, 64'hDEAD_BEEF_0000_0000, 5'd11},
                    '{1'b0, 64'h6000, 64'h0, 8'h00, 64'h0000_0000_DEAD_BEEF, 5'd11}};
`endif
        vecs[6] = '{'{1'b0, 3'b111, 64'h8008, 64'h0, 64'h1234, 5'd9},
                    '{1'b1, 64'h0, 64'h0, 8'h00, 64'h0, 5'd9}};
        vecs[7] = '{'{1'b1, 3'b100, 64'h8000, 64'h55, 64'h0, 5'd4},
                    '{1'b1, 64'h0, 64'h0, 8'h00, 64'h0, 5'd0}};
        vecs[8] = '{'{1'b0, 3'b101, 64'h5006, 64'h0, 64'h8765_0000_0000_0000, 5'd12},
                    '{1'b0, 64'h5000, 64'h0, 8'h00, 64'h0000_0000_0000_8765, 5'd12}};
        vecs[9] = '{'{1'b1, 3'b000, 64'h7005, 64'hAB, 64'h0, 5'd13},
                    '{1'b0, 64'h7000, 64'h0000_AB00_0000_0000, 8'h20, 64'h0, 5'd0}};

        reset = 1'b1; in_valid = 1'b0; addr = 64'h0; wdata = 64'h0; funct3 = 3'b000;
        is_store = 1'b0; rd = 5'd0; mem_ack = 1'b0; mem_rdata = 64'h0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_wstrb", mem_wstrb, 8'h00);
        chk("rst_mem_addr", mem_addr, 64'h0);
        chk("rst_mem_wdata", mem_wdata, 64'h0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_rdata", out_rdata, 64'h0);
        chk("rst_out_rd", out_rd, 5'd0);
        chk("rst_out_fault", out_fault, 1'b0);
        reset = 1'b0;

        // mem_ack while idle must not start anything.
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 64'hFFFF;
        repeat (2) @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_ack_out_valid", out_valid, 1'b0);
        chk("idle_ack_mem_req", mem_req, 1'b0);
        chk("idle_ack_in_ready", in_ready, 1'b1);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, 0, 0, res);
            check_res($sformatf("vec%0d", i), vecs[i].op, vecs[i].e, res, 2);
        end

        // Backpressure: ack held off 5 cycles, result held 3 cycles.
        op = '{1'b0, 3'b001, 64'hA00A, 64'h0, 64'h0000_C3A5_0000_0000, 5'd17};
        run_op(op, 5, 3, res);
        check_res("bp", op, model(op), res, 7);

        // Reset while the request is outstanding; a late ack is ignored.
        @(negedge clk);
        in_valid = 1'b1; is_store = 1'b0; funct3 = 3'b011; addr = 64'h9000; rd = 5'd3;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_rst_req_before", mem_req, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_mem_req", mem_req, 1'b0);
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        mem_ack = 1'b1; mem_rdata = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_out_valid", out_valid, 1'b0);
        chk("late_ack_mem_req", mem_req, 1'b0);
        chk("late_ack_in_ready", in_ready, 1'b1);

        for (int i = 0; i < 200; i++) begin
            op.st    = 1'($urandom_range(0, 1));
            op.f3    = 3'($urandom_range(0, 7));
            op.addr  = {$urandom, $urandom};
            op.wdata = {$urandom, $urandom};
            op.rdata = {$urandom, $urandom};
            op.rd    = 5'($urandom_range(0, 31));
            ad       = $urandom_range(0, 3);
            rdl      = $urandom_range(0, 2);
            ex       = model(op);
            run_op(op, ad, rdl, res);
            check_res($sformatf("rnd%0d", i), op, ex, res, ad + 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
